dout_window_mem: RTL and testbench

DOUT_WINDOW_MEM -- requirements
Module: dout_window_mem

---
 rtl/dout_window_mem.sv | 127 ++++++++++++
 tb/tb_dout_window_mem.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dout_window_mem.sv
// Address-windowed word memory: host read latency 1, plus a drain engine that streams all words in order.
// Drain output: a 2-entry buffer with valid/ready; stalls hold data, and 1 word/cycle when out_ready is high.
module dout_window_mem #(
  parameter int WIDTH = 24,
  parameter int AW    = 24,
  parameter int DEPTH = 90000,
  parameter int BASE  = 90302
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    a,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] rd,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             err,
  input  logic             err_clr
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);
  localparam logic [AW:0] LO = (AW+1)'(BASE);
  localparam logic [AW:0] HI = (AW+1)'(BASE + DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             hit;
  logic [IW-1:0]    idx;
  logic [PW-1:0]    ptr;

  logic [1:0]       occ;
  logic [WIDTH-1:0] b0, b1;
  logic             l0, l1;
  logic             infl, infl_last;
  logic [WIDTH-1:0] infl_dat;
  logic             pop, fetch;
  logic [1:0]       pend;

  // Window decode is done one bit wider than the address so BASE+DEPTH never wraps.
  assign hit = ({1'b0, a} >= LO) && ({1'b0, a} < HI);
  assign idx = IW'({1'b0, a} - LO);

  assign out_valid = (occ != 2'd0);
  assign out_data  = b0;
  assign out_last  = l0 && out_valid;
  assign pop       = out_valid && out_ready;
  // Occupancy after this edge, counting the read that lands now and the word leaving now.
  assign pend      = occ + {1'b0, infl} - {1'b0, pop};
  assign fetch     = busy && (ptr != PW'(DEPTH)) && (pend < 2'd2);

  always_ff @(posedge clk) begin
    if (we && hit && !busy) mem[idx] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ptr       <= '0;
      rd        <= '0;
      err       <= 1'b0;
      occ       <= 2'd0;
      b0        <= '0;
      b1        <= '0;
      l0        <= 1'b0;
      l1        <= 1'b0;
      infl      <= 1'b0;
      infl_dat  <= '0;
      infl_last <= 1'b0;
    end else begin
      if (!busy) rd <= hit ? mem[idx] : '0;

      if (we && (!hit || busy)) err <= 1'b1;
      else if (err_clr)         err <= 1'b0;

      infl <= fetch;
      if (fetch) begin
        infl_dat  <= mem[ptr[IW-1:0]];
        infl_last <= (ptr == PW'(DEPTH - 1));
        ptr       <= ptr + PW'(1);
      end

      if (pop) begin
        b0 <= b1;
        l0 <= l1;
      end
      if (infl) begin
        if ((occ - {1'b0, pop}) == 2'd0) begin
          b0 <= infl_dat;
          l0 <= infl_last;
        end else begin
          b1 <= infl_dat;
          l1 <= infl_last;
        end
      end
      occ <= pend;

      case (state)
        IDLE: if (start) begin
          state <= DRAIN;
          busy  <= 1'b1;
          ptr   <= '0;
        end
        DRAIN: if (pop && out_last) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dout_window_mem.sv
// Bench for dout_window_mem (WIDTH=8, AW=8, DEPTH=8, BASE=16): random host traffic and drains
// checked against an array model of the window and a transfer log of the stream port.
module tb_dout_window_mem;
  localparam int WIDTH = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int BASE  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             we = 1'b0;
  logic [AW-1:0]    a = '0;
  logic [WIDTH-1:0] wd = '0;
  logic [WIDTH-1:0] rd;
  logic             start = 1'b0;
  logic             busy, done, out_valid, out_last, err;
  logic             out_ready = 1'b0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem_m [DEPTH];
  bit         known [DEPTH];
  bit         err_m = 1'b0;

  always #5 clk = ~clk;

  dout_window_mem #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .a(a), .wd(wd), .rd(rd),
    .start(start), .busy(busy), .done(done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err(err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd"}, {24'd0, rd}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_last"}, {31'd0, out_last}, 0);
    chk({tag, "_data"}, {24'd0, out_data}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
  endtask

  // One host cycle: apply inputs, clock, then compare rd/err with the window model.
  task automatic host_cycle(input string tag, input bit w, input int addr,
                            input logic [7:0] d, input bit clr);
    int         ix;
    bit         h, can;
    logic [7:0] exp_rd;
    we = w; a = addr[7:0]; wd = d; err_clr = clr;
    h  = (addr >= BASE) && (addr < BASE + DEPTH);
    ix = addr - BASE;
    exp_rd = 8'h00;
    can = 1'b1;
    if (h) begin
      exp_rd = mem_m[ix];
      can    = known[ix];
    end
    @(posedge clk); #1;
    if (w && h) begin
      mem_m[ix] = d;
      known[ix] = 1'b1;
    end
    if (w && !h)  err_m = 1'b1;
    else if (clr) err_m = 1'b0;
    if (can) chk({tag, "_rd"}, {24'd0, rd}, {24'd0, exp_rd});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, err_m});
    we = 1'b0; err_clr = 1'b0;
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_drain(input int mode, input bit inject, input int abort_at);
    logic [7:0] got[$];
    int         cyc, nx, first_v, done_cyc, last_obs;
    bit         finished, aborted, prev_stall, prev_last, busy_at_done;
    logic [7:0] prev_dat, hold_exp;
    nx = 0; first_v = -1; done_cyc = -1; last_obs = -100;
    finished = 0; aborted = 0; prev_stall = 0; prev_last = 0; prev_dat = 0;
    busy_at_done = 1;
    hold_exp = mem_m[3];
    we = 0; a = 8'(BASE + 3); start = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    chk("busy_on_start", {31'd0, busy}, 1);
    while (!finished && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      we = 1'b0; start = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 1);
        chk("stall_data", {24'd0, out_data}, {24'd0, prev_dat});
        chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (cyc == 5) chk("rd_hold", {24'd0, rd}, {24'd0, hold_exp});
      if (done) begin
        done_cyc = cyc;
        busy_at_done = busy;
        finished = 1;
      end else if (abort_at > 0 && nx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        err_m = 1'b0;
        aborted = 1;
        finished = 1;
      end else begin
        if (out_valid && first_v < 0) first_v = cyc;
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid && out_ready) begin
          got.push_back(out_data);
          chk("last_flag", {31'd0, out_last}, {31'd0, (nx == DEPTH - 1)});
          nx++;
          last_obs = cyc;
        end
        prev_stall = out_valid && !out_ready;
        prev_dat   = out_data;
        prev_last  = out_last;
        if (inject && cyc == 3) begin
          we = 1'b1; a = 8'(BASE + 2); wd = 8'hEE; start = 1'b1;
          err_m = 1'b1;
        end
      end
    end
    out_ready = 1'b0;
    chk("drain_finished", {31'd0, finished}, 1);
    if (aborted) begin
      chk("abort_count", nx, abort_at);
    end else begin
      chk("drain_count", nx, DEPTH);
      foreach (got[i]) chk("drain_data", {24'd0, got[i]}, {24'd0, mem_m[i]});
      chk("first_valid", first_v, 2);
      chk("done_timing", done_cyc, last_obs + 1);
      chk("busy_at_done", {31'd0, busy_at_done}, 0);
      if (mode == 0) chk("back_to_back", last_obs - first_v, DEPTH - 1);
      chk("err_after_drain", {31'd0, err}, {31'd0, err_m});
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done}, 0);
      chk("busy_after", {31'd0, busy}, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    host_cycle("wr_a5", 1, 16, 8'hA5, 0);
    host_cycle("rd_a5", 0, 16, 8'h00, 0);
    host_cycle("rdw_old", 1, 16, 8'h3C, 0);
    host_cycle("rdw_new", 0, 16, 8'h00, 0);
    host_cycle("rd_miss", 0, 40, 8'h00, 0);

    host_cycle("we_lo", 1, 15, 8'h77, 0);
    host_cycle("clr", 0, 16, 8'h00, 1);
    host_cycle("we_hi", 1, 24, 8'h66, 0);
    host_cycle("set_clr", 1, 30, 8'h00, 1);
    host_cycle("clr2", 0, 16, 8'h00, 1);

    for (int i = 0; i < DEPTH; i++) host_cycle("prefill", 1, BASE + i, 8'h40 + 8'(i), 0);
    repeat (150) begin
      int ra;
      ra = 12 + int'($urandom_range(0, 15));
      host_cycle("rand", 1'($urandom_range(0, 1)), ra, 8'($urandom), $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < DEPTH; i++) host_cycle("fill", 1, BASE + i, 8'h10 + 8'(i), 0);
    host_cycle("fill_clr", 0, 16, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) host_cycle("readback", 0, BASE + i, 8'h00, 0);

    run_drain(0, 0, 0);
    run_drain(1, 0, 0);
    run_drain(2, 1, 0);
    host_cycle("word2_kept", 0, 18, 8'h00, 0);
    host_cycle("busy_err_clr", 0, 18, 8'h00, 1);

    run_drain(0, 0, 3);
    run_drain(0, 0, 0);
    run_drain(2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
